// File: rtl/instruction_decode_stage_pkg.sv
// Shared operand-type constants, field-offset helpers and the decoded-instruction record
// for instruction_decode_stage.
package ace_decode_pkg;

  localparam logic OPERAND_REG = 1'b0;
  localparam logic OPERAND_IMM = 1'b1;

  // The record is sized for the widest supported configuration; the stage uses the low bits.
  localparam int unsigned MAX_OPC_W = 8;
  localparam int unsigned MAX_IMM_W = 32;
  localparam int unsigned MAX_REG_W = 8;

  typedef struct packed {
    logic [MAX_OPC_W-1:0] opcode;
    logic                 type_1;
    logic [MAX_REG_W-1:0] reg_1;
    logic [MAX_IMM_W-1:0] imm_1;
    logic                 type_2;
    logic [MAX_REG_W-1:0] reg_2;
    logic [MAX_IMM_W-1:0] imm_2;
    logic [MAX_REG_W-1:0] dest;
    logic                 illegal;
  } dec_instr_t;

  function automatic int unsigned opc_lsb(int unsigned instr_w, int unsigned opc_w);
    return instr_w - opc_w;
  endfunction

  function automatic int unsigned type1_bit(int unsigned instr_w, int unsigned opc_w);
    return instr_w - opc_w - 1;
  endfunction

  function automatic int unsigned field1_lsb(int unsigned instr_w, int unsigned opc_w,
                                             int unsigned imm_w);
    return instr_w - opc_w - 1 - imm_w;
  endfunction

  function automatic int unsigned type2_bit(int unsigned instr_w, int unsigned opc_w,
                                            int unsigned imm_w);
    return instr_w - opc_w - 2 - imm_w;
  endfunction

  function automatic int unsigned field2_lsb(int unsigned instr_w, int unsigned opc_w,
                                             int unsigned imm_w);
    return instr_w - opc_w - 2 - 2 * imm_w;
  endfunction

  // Destination sits directly above the reserved bits, so this is also the reserved width.
  function automatic int unsigned dest_lsb(int unsigned instr_w, int unsigned opc_w,
                                           int unsigned imm_w, int unsigned reg_w);
    return instr_w - opc_w - 2 - 2 * imm_w - reg_w;
  endfunction

endpackage

// File: rtl/decode_scoreboard.sv
// Per-register pending bits for the decode stage; reports read/write hazards on the
// incoming word, with writeback clears bypassed into the same-cycle check.
module decode_scoreboard
  import ace_decode_pkg::*;
#(
  parameter int unsigned REG_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_flush,
  input  logic             i_set_en,
  input  logic [REG_W-1:0] i_set_reg,
  input  logic             i_clr_en,
  input  logic [REG_W-1:0] i_clr_reg,
  input  logic             i_chk_en,
  input  logic             i_type_1,
  input  logic [REG_W-1:0] i_reg_1,
  input  logic             i_type_2,
  input  logic [REG_W-1:0] i_reg_2,
  input  logic [REG_W-1:0] i_dest,
  output logic             o_hazard
);

  localparam int unsigned NREG = 2 ** REG_W;

  logic [NREG-1:0] r_pending;
  logic [NREG-1:0] w_clr_mask;
  logic [NREG-1:0] w_set_mask;
  logic [NREG-1:0] w_live;

  always_comb begin
    w_clr_mask = '0;
    w_set_mask = '0;
    if (i_clr_en) w_clr_mask[i_clr_reg] = 1'b1;
    if (i_set_en) w_set_mask[i_set_reg] = 1'b1;
  end

  assign w_live = r_pending & ~w_clr_mask;

  assign o_hazard = i_chk_en &&
                    (((i_type_1 == OPERAND_REG) && w_live[i_reg_1]) ||
                     ((i_type_2 == OPERAND_REG) && w_live[i_reg_2]) ||
                     w_live[i_dest]);

  // Set is ORed after the clear so a same-cycle set and clear of one register leaves it pending.
  always_ff @(posedge clk) begin
    if (reset || i_flush) begin
      r_pending <= '0;
    end else begin
      r_pending <= w_live | w_set_mask;
    end
  end

endmodule

// File: rtl/instruction_decode_stage.sv
// Registered instruction decode stage with valid/ready on both sides.
// Define ACE_DECODE_SCOREBOARD_EN to enable register-hazard stalling.
module instruction_decode_stage
  import ace_decode_pkg::*;
#(
  parameter int unsigned           OPC_W          = 4,
  parameter int unsigned           IMM_W          = 8,
  parameter int unsigned           REG_W          = 2,
  parameter int unsigned           INSTR_W        = 32,
  parameter logic [2**OPC_W-1:0]   LEGAL_OPC_MASK = '1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OPC_W-1:0]   out_opcode,
  output logic               out_type_1,
  output logic               out_type_2,
  output logic [REG_W-1:0]   out_reg_1,
  output logic [REG_W-1:0]   out_reg_2,
  output logic [IMM_W-1:0]   out_imm_1,
  output logic [IMM_W-1:0]   out_imm_2,
  output logic [REG_W-1:0]   out_dest,
  output logic               out_illegal,
  input  logic               wb_valid,
  input  logic [REG_W-1:0]   wb_reg
);

  localparam int unsigned OPC_LSB  = opc_lsb(INSTR_W, OPC_W);
  localparam int unsigned T1_BIT   = type1_bit(INSTR_W, OPC_W);
  localparam int unsigned F1_LSB   = field1_lsb(INSTR_W, OPC_W, IMM_W);
  localparam int unsigned T2_BIT   = type2_bit(INSTR_W, OPC_W, IMM_W);
  localparam int unsigned F2_LSB   = field2_lsb(INSTR_W, OPC_W, IMM_W);
  localparam int unsigned DEST_LSB = dest_lsb(INSTR_W, OPC_W, IMM_W, REG_W);
  localparam int unsigned RSV_W    = DEST_LSB;

  logic       w_rsv_set;
  logic       w_hazard;
  logic       w_ready;
  logic       w_accept;
  dec_instr_t w_dec;
  dec_instr_t r_dec;
  logic       r_out_valid;

  if (RSV_W > 0) begin : g_rsv
    assign w_rsv_set = |in_instr[RSV_W-1:0];
  end else begin : g_no_rsv
    assign w_rsv_set = 1'b0;
  end

  always_comb begin
    w_dec                   = '0;
    w_dec.opcode[OPC_W-1:0] = in_instr[OPC_LSB +: OPC_W];
    w_dec.type_1            = in_instr[T1_BIT];
    w_dec.imm_1[IMM_W-1:0]  = in_instr[F1_LSB +: IMM_W];
    w_dec.reg_1[REG_W-1:0]  = in_instr[F1_LSB + IMM_W - REG_W +: REG_W];
    w_dec.type_2            = in_instr[T2_BIT];
    w_dec.imm_2[IMM_W-1:0]  = in_instr[F2_LSB +: IMM_W];
    w_dec.reg_2[REG_W-1:0]  = in_instr[F2_LSB + IMM_W - REG_W +: REG_W];
    w_dec.dest[REG_W-1:0]   = in_instr[DEST_LSB +: REG_W];
    w_dec.illegal           = !LEGAL_OPC_MASK[in_instr[OPC_LSB +: OPC_W]] || w_rsv_set;
  end

`ifdef ACE_DECODE_SCOREBOARD_EN
  // Illegal words neither stall nor reserve their destination.
  decode_scoreboard #(
    .REG_W (REG_W)
  ) u_scoreboard (
    .clk       (clk),
    .reset     (reset),
    .i_flush   (flush),
    .i_set_en  (w_accept && !w_dec.illegal),
    .i_set_reg (w_dec.dest[REG_W-1:0]),
    .i_clr_en  (wb_valid),
    .i_clr_reg (wb_reg),
    .i_chk_en  (!w_dec.illegal),
    .i_type_1  (w_dec.type_1),
    .i_reg_1   (w_dec.reg_1[REG_W-1:0]),
    .i_type_2  (w_dec.type_2),
    .i_reg_2   (w_dec.reg_2[REG_W-1:0]),
    .i_dest    (w_dec.dest[REG_W-1:0]),
    .o_hazard  (w_hazard)
  );
`else
  logic w_unused_wb;
  assign w_unused_wb = ^{wb_valid, wb_reg};
  assign w_hazard    = 1'b0;
`endif

  assign w_ready  = !reset && !flush && (!r_out_valid || out_ready) && !w_hazard;
  assign w_accept = in_valid && w_ready;
  assign in_ready = w_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_dec       <= '0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_dec       <= w_dec;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid   = r_out_valid;
  assign out_opcode  = r_dec.opcode[OPC_W-1:0];
  assign out_type_1  = r_dec.type_1;
  assign out_type_2  = r_dec.type_2;
  assign out_reg_1   = r_dec.reg_1[REG_W-1:0];
  assign out_reg_2   = r_dec.reg_2[REG_W-1:0];
  assign out_imm_1   = r_dec.imm_1[IMM_W-1:0];
  assign out_imm_2   = r_dec.imm_2[IMM_W-1:0];
  assign out_dest    = r_dec.dest[REG_W-1:0];
  assign out_illegal = r_dec.illegal;

  // Upper bits of the shared record are unused in narrower configurations.
  logic w_unused_dec;
  assign w_unused_dec = ^r_dec;

endmodule

// File: tb/tb_instruction_decode_stage.sv
// Scoreboard bench for instruction_decode_stage: directed cases followed by random traffic,
// checked against a field-arithmetic reference model.
module tb_instruction_decode_stage;

  localparam int unsigned OPC_W   = 4;
  localparam int unsigned IMM_W   = 8;
  localparam int unsigned REG_W   = 2;
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned RSV_W   = INSTR_W - OPC_W - 2 * (1 + IMM_W) - REG_W;
  localparam int unsigned NREG    = 1 << REG_W;
  localparam longint unsigned LEGAL = 64'hFFFF;
  localparam int unsigned EXP_W   = OPC_W + 2 * (1 + REG_W + IMM_W) + REG_W + 1;

  localparam logic [INSTR_W-1:0] INSTR_A   = 32'h1604A900;
  localparam logic [INSTR_W-1:0] INSTR_B   = 32'h22040600;
  localparam logic [INSTR_W-1:0] INSTR_ILL = 32'h1604A901;

  typedef logic [EXP_W-1:0] exp_t;

  logic               clk = 1'b0;
  logic               reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [INSTR_W-1:0] in_instr;
  logic [OPC_W-1:0]   out_opcode;
  logic               out_type_1, out_type_2, out_illegal, wb_valid;
  logic [REG_W-1:0]   out_reg_1, out_reg_2, out_dest, wb_reg;
  logic [IMM_W-1:0]   out_imm_1, out_imm_2;

  exp_t exp_q[$];
  bit   pending[NREG];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  instruction_decode_stage dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_opcode (out_opcode),
    .out_type_1 (out_type_1),
    .out_type_2 (out_type_2),
    .out_reg_1  (out_reg_1),
    .out_reg_2  (out_reg_2),
    .out_imm_1  (out_imm_1),
    .out_imm_2  (out_imm_2),
    .out_dest   (out_dest),
    .out_illegal(out_illegal),
    .wb_valid   (wb_valid),
    .wb_reg     (wb_reg)
  );

  function automatic longint unsigned fld(longint unsigned w, int lsb, int width);
    return (w >> lsb) & ((64'd1 << width) - 64'd1);
  endfunction

  function automatic bit model_illegal(logic [INSTR_W-1:0] instr);
    longint unsigned w   = 64'(instr);
    longint unsigned opc = fld(w, INSTR_W - OPC_W, OPC_W);
    return (((LEGAL >> opc) & 64'd1) == 64'd0) || (fld(w, 0, RSV_W) != 64'd0);
  endfunction

  function automatic exp_t model_decode(logic [INSTR_W-1:0] instr);
    longint unsigned w  = 64'(instr);
    longint unsigned f1 = fld(w, INSTR_W - OPC_W - 1 - IMM_W, IMM_W);
    longint unsigned f2 = fld(w, INSTR_W - OPC_W - 2 - 2 * IMM_W, IMM_W);
    return {OPC_W'(fld(w, INSTR_W - OPC_W, OPC_W)),
            1'(fld(w, INSTR_W - OPC_W - 1, 1)), REG_W'(f1 >> (IMM_W - REG_W)), IMM_W'(f1),
            1'(fld(w, INSTR_W - OPC_W - 2 - IMM_W, 1)), REG_W'(f2 >> (IMM_W - REG_W)),
            IMM_W'(f2), REG_W'(fld(w, RSV_W, REG_W)), model_illegal(instr)};
  endfunction

  // A register is busy if pending and not being retired this very cycle.
  function automatic bit busy(int r, bit wbv, int wbr);
    return pending[r] && !(wbv && (wbr == r));
  endfunction

  function automatic bit model_hazard(logic [INSTR_W-1:0] instr, bit wbv, int wbr);
    longint unsigned w  = 64'(instr);
    int r1 = int'(fld(w, INSTR_W - OPC_W - 1 - REG_W, REG_W));
    int r2 = int'(fld(w, INSTR_W - OPC_W - 2 - IMM_W - REG_W, REG_W));
    int d  = int'(fld(w, RSV_W, REG_W));
    bit t1 = fld(w, INSTR_W - OPC_W - 1, 1) != 0;
    bit t2 = fld(w, INSTR_W - OPC_W - 2 - IMM_W, 1) != 0;
    bit h  = !model_illegal(instr) &&
             ((!t1 && busy(r1, wbv, wbr)) || (!t2 && busy(r2, wbv, wbr)) || busy(d, wbv, wbr));
`ifdef ACE_DECODE_SCOREBOARD_EN
    return h;
`else
    return h && 1'b0;
`endif
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t dut_outs();
    return {out_opcode, out_type_1, out_reg_1, out_imm_1, out_type_2, out_reg_2, out_imm_2,
            out_dest, out_illegal};
  endfunction

  // One clock of stimulus: drive, check in_ready, then advance the model for the coming edge.
  task automatic cycle(input bit rst, input bit fl, input bit iv, input logic [INSTR_W-1:0] instr,
                       input bit ordy, input bit wbv, input int wbr);
    bit exp_ready;
    bit acc;
    @(negedge clk);
    reset     = rst;
    flush     = fl;
    in_valid  = iv;
    in_instr  = instr;
    out_ready = ordy;
    wb_valid  = wbv;
    wb_reg    = REG_W'(wbr);
    #1;
    exp_ready = !rst && !fl && (exp_q.size() == 0 || ordy) && !model_hazard(instr, wbv, wbr);
    check("in_ready", 64'(in_ready), 64'(exp_ready));
    acc = iv && exp_ready;
    #2;
    if (rst || fl) begin
      exp_q.delete();
      foreach (pending[i]) pending[i] = 1'b0;
    end else begin
      if (wbv) pending[wbr] = 1'b0;
      if (acc) begin
        exp_q.push_back(model_decode(instr));
        if (!model_illegal(instr)) pending[int'(fld(64'(instr), RSV_W, REG_W))] = 1'b1;
      end
    end
  endtask

  // Monitor: compares presented outputs with the head of the expected queue.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      check("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        check("out_fields", 64'(dut_outs()), 64'(exp_q[0]));
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    logic [INSTR_W-1:0] instr;
    bit rst, fl, iv, ordy, wbv;
    int wbr;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0;
    out_ready = 1'b0; wb_valid = 1'b0; wb_reg = '0;

    cycle(1, 0, 0, '0, 1, 0, 0);
    cycle(1, 0, 1, INSTR_A, 1, 0, 0);
    check("reset_outs", 64'(dut_outs()), 64'd0);

    // Decode example, then a dependent read of r1 that waits for writeback.
    cycle(0, 0, 1, INSTR_A, 1, 0, 0);
    cycle(0, 0, 1, INSTR_B, 1, 0, 0);
    check("decode_A", 64'(dut_outs()),
          64'({4'd1, 1'b0, 2'd3, 8'hC0, 1'b1, 2'd0, 8'd42, 2'd1, 1'b0}));
    cycle(0, 0, 1, INSTR_B, 1, 0, 0);
    cycle(0, 0, 1, INSTR_B, 1, 1, 1);
    cycle(0, 0, 0, '0, 0, 0, 0);
    check("dest_B", 64'(out_dest), 64'd2);
    cycle(0, 1, 0, '0, 1, 0, 0);

    // Illegal word passes through and does not reserve r1.
    cycle(0, 0, 1, INSTR_ILL, 1, 0, 0);
    cycle(0, 0, 1, INSTR_B, 1, 0, 0);
    check("illegal_flag", 64'(out_illegal), 64'd1);

    // Backpressure: held outputs, no accept, then release.
    cycle(0, 0, 1, INSTR_A, 0, 0, 0);
    cycle(0, 0, 1, INSTR_A, 0, 0, 0);
    cycle(0, 0, 1, INSTR_A, 0, 0, 0);
    cycle(0, 0, 1, INSTR_A, 1, 0, 0);

    // Flush and reset each drop the output and clear the r1 reservation.
    cycle(0, 1, 0, '0, 0, 0, 0);
    cycle(0, 0, 1, INSTR_B, 1, 0, 0);
    cycle(0, 0, 1, INSTR_A, 1, 1, 2);
    cycle(1, 0, 0, '0, 0, 0, 0);
    cycle(0, 0, 1, INSTR_B, 1, 0, 0);
    cycle(0, 1, 0, '0, 1, 0, 0);

    // Back-to-back A then B (stalls only when hazard stalling is built in).
    cycle(0, 0, 1, INSTR_A, 1, 0, 0);
    cycle(0, 0, 1, INSTR_B, 1, 0, 0);

    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom_range(0, 199) == 0);
      fl    = ($urandom_range(0, 39) == 0);
      iv    = ($urandom_range(0, 3) != 0);
      ordy  = ($urandom_range(0, 3) != 0);
      wbv   = ($urandom_range(0, 2) == 0);
      wbr   = int'($urandom_range(0, NREG - 1));
      instr = INSTR_W'($urandom);
      if ($urandom_range(0, 7) != 0) instr[RSV_W-1:0] = '0;
      cycle(rst, fl, iv, instr, ordy, wbv, wbr);
    end

    cycle(0, 0, 0, '0, 1, 0, 0);
    cycle(0, 0, 0, '0, 1, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
